mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Upstream access sequencer for mem_top (4 banks x 1024 x 8, 12-bit address, bank = add[11:10]).
- Accepts burst requests over a valid/ready handshake: start address, length, direction.
- Drives mem_top's cen/wr/rd/add/din one byte at a time, holding each access for a fixed number of cycles.
- Streams write data in and read data out, each with its own handshake.

Parameters:
- ADDR_W, 12, memory address width (bank in top 2 bits)
- DATA_W, 8, data width
- LEN_W, 8, burst length field width (burst = req_len+1 bytes, 1..256)
- WR_CYCLES, 2, clocks mem_wr is held per byte (>=1)
- RD_CYCLES, 2, clocks mem_rd is held per byte before dout is sampled (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  byte count minus 1
- wdata_valid  in  1  write byte valid
- wdata_ready  out  1  controller accepts write byte
- wdata  in  DATA_W  write byte
- rdata_valid  out  1  read byte valid
- rdata_ready  in  1  consumer accepts read byte
- rdata  out  DATA_W  read byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at burst completion
- mem_cen  out  1  memory chip enable, active-low
- mem_wr, mem_rd  out  1 each  memory write/read strobes
- mem_add  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, async): state IDLE; mem_cen=1, mem_wr=0, mem_rd=0, mem_add=0, mem_din=0, rdata=0, rdata_valid=0, wdata_ready=0, done=0, busy=0.
- Reset mid-burst aborts the burst immediately. No partial state survives; the next request starts clean.
- States: IDLE, WFETCH, WRITE, RACC, RDRAIN, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, remaining count=req_len and direction. Next state is WFETCH (write) or RACC (read).
- WFETCH: wdata_ready=1, mem_cen=1. On wdata_valid, latch wdata into mem_din and go to WRITE.
- WRITE: mem_cen=0, mem_wr=1, mem_add=current address, held exactly WR_CYCLES clocks. Then:
  - remaining==0: go to DONE.
  - otherwise: address+1, remaining-1, go to WFETCH.
- RACC: mem_cen=0, mem_rd=1, held RD_CYCLES clocks. mem_dout is captured into rdata on the last held clock. Then go to RDRAIN.
- RDRAIN: rdata_valid=1, mem_cen=1, rdata stable. When rdata_ready=1:
  - remaining==0: go to DONE.
  - otherwise: address+1, remaining-1, go to RACC.
- DONE: done=1 for one clock, then IDLE. req_ready=0 in DONE, so the earliest next accept is the cycle after.
- Address increment is linear modulo 2^ADDR_W. 0x3FF->0x400 crosses banks with no gap; 0xFFF->0x000 wraps.
- mem_wr and mem_rd are never high together. Outside WRITE/RACC, mem_cen=1 and both strobes are 0.
- Upstream stalls (no wdata_valid, rdata_ready low) hold the current state indefinitely; memory stays disabled.
- req_valid is ignored outside IDLE.
- Minimum write-burst throughput: 1+WR_CYCLES clocks per byte.

Decomposition:
- Package mem_pkg holds: the state enum; ADDR_W/DATA_W defaults; BANK_MSB=11, BANK_LSB=10; the mem_top geometry constants (4 banks, 1024 deep).
- One sub-module, mem_hold_cnt: a loadable down-counter that generates the WR_CYCLES/RD_CYCLES hold-done strobe.

Test Plan:
- Single write: req_wr=1, addr=0x3FF, len=0, wdata=0xA5 -> mem_add=0x3FF, mem_din=0xA5, mem_wr high exactly 2 clocks, done pulses once, uut.memory[0][1023]=0xA5.
- Bank-crossing write: addr=0x3FE, len=3, data 0x11,0x22,0x33,0x44 -> mem_add sequence 0x3FE,0x3FF,0x400,0x401; memory banks 0/1 hold those bytes.
- Read-back with backpressure: read addr=0x3FE, len=3, rdata_ready low 5 clocks per byte -> rdata 0x11,0x22,0x33,0x44; mem_cen=1 during stalls; rdata stable while valid.
- Wrap: write addr=0xFFF, len=1, data 0x5A,0xC3 -> bytes land at 0xFFF and 0x000.
- Write starvation: wdata_valid withheld 10 clocks -> mem_cen=1, mem_wr=0 throughout; burst resumes correctly.
- Reset mid-burst: assert rst=0 during 2nd WRITE of a len=3 burst -> all outputs at reset values within the same cycle; a new single read after release returns correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and mem_top geometry for the burst sequencer
package mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int BANK_MSB   = 11;
  localparam int BANK_LSB   = 10;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WFETCH,
    ST_WRITE,
    ST_RACC,
    ST_RDRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_hold_cnt.sv
// rtl/mem_hold_cnt.sv - loadable down-counter flagging the last clock of a memory access hold
module mem_hold_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  // Loaded with hold-1 on entry, so last is high on the final held clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst sequencer driving mem_top one byte per timed access
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int HOLD_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  state_t            state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata_q;
  logic              hold_load;
  logic [CNT_W-1:0]  hold_val;
  logic              hold_last;
  logic              last_byte;

  assign last_byte = (rem_q == '0);

  mem_hold_cnt #(.W(CNT_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst),
    .load     (hold_load),
    .load_val (hold_val),
    .last     (hold_last)
  );

  always_comb begin
    next        = state;
    hold_load   = 1'b0;
    hold_val    = WR_LOAD;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    done        = 1'b0;
    mem_cen     = 1'b1;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_wr) begin
            next = ST_WFETCH;
          end else begin
            next      = ST_RACC;
            hold_load = 1'b1;
            hold_val  = RD_LOAD;
          end
        end
      end
      ST_WFETCH: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          next      = ST_WRITE;
          hold_load = 1'b1;
          hold_val  = WR_LOAD;
        end
      end
      ST_WRITE: begin
        mem_cen = 1'b0;
        mem_wr  = 1'b1;
        if (hold_last) next = last_byte ? ST_DONE : ST_WFETCH;
      end
      ST_RACC: begin
        mem_cen = 1'b0;
        mem_rd  = 1'b1;
        if (hold_last) next = ST_RDRAIN;
      end
      ST_RDRAIN: begin
        rdata_valid = 1'b1;
        if (rdata_ready) begin
          if (last_byte) begin
            next = ST_DONE;
          end else begin
            next      = ST_RACC;
            hold_load = 1'b1;
            hold_val  = RD_LOAD;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
        next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  // Address and count advance only when a byte retires, never mid-hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            rem_q  <= req_len;
          end
        end
        ST_WFETCH: begin
          if (wdata_valid) din_q <= wdata;
        end
        ST_WRITE: begin
          if (hold_last && !last_byte) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
          end
        end
        ST_RACC: begin
          if (hold_last) rdata_q <= mem_dout;
        end
        ST_RDRAIN: begin
          if (rdata_ready && !last_byte) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_add = addr_q;
  assign mem_din = din_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed and random burst bench with a byte-array reference model
module tb_mem_burst_ctrl;
  import mem_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int WRC = 2;
  localparam int RDC = 2;
  localparam int MEM_SIZE = NUM_BANKS * BANK_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          busy, done;
  logic          mem_cen, mem_wr, mem_rd;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_din, mem_dout;

  mem_burst_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)
  ) uut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .mem_cen(mem_cen), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n;
  } wev_t;

  // phys_mem stands in for mem_top and is written only by DUT strobes
  logic [DW-1:0] phys_mem [MEM_SIZE];
  logic [DW-1:0] ref_mem  [MEM_SIZE];
  wev_t          act_q[$];
  wev_t          exp_q[$];
  logic [DW-1:0] wbytes[$];
  int            ev_idx = 0;
  int            run_len = 0;
  logic [AW-1:0] run_a;
  logic [DW-1:0] run_d;
  int            bad_strobe = 0;
  int            cyc = 0;
  bit            mem_init_done = 1'b0;
  int            t_acc = 0;
  int            t_done = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  assign mem_dout = phys_mem[mem_add];

  always @(posedge clk) begin
    wev_t e;
    cyc++;
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_SIZE; i++) phys_mem[i] = '0;
      mem_init_done = 1'b1;
    end
    if (!rst) begin
      run_len = 0;
    end else begin
      if ((mem_wr && mem_rd) || ((mem_wr || mem_rd) && mem_cen)) bad_strobe++;
      if (mem_wr) begin
        if (run_len == 0) begin
          run_a = mem_add;
          run_d = mem_din;
        end
        run_len++;
      end else if (run_len != 0) begin
        e.a = run_a; e.d = run_d; e.n = run_len;
        act_q.push_back(e);
        run_len = 0;
      end
      if (!mem_cen && mem_wr) phys_mem[mem_add] = mem_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
    int t = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = len;
    while (!req_ready && t < 50) begin tick(); t++; end
    chk("req_ready", req_ready, 1);
    tick();
    t_acc = cyc;
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_addr = AW'($urandom); req_len = LW'($urandom);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input int stall);
    int t = 0;
    while (!wdata_ready && t < 50) begin tick(); t++; end
    chk("wdata_ready", wdata_ready, 1);
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'($urandom);
      req_wr    = 1'($urandom);
      chk("wstall_outs", {mem_cen, mem_wr, mem_rd, wdata_ready, req_ready}, 5'b10010);
      tick();
    end
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = d;
    tick();
    wdata_valid = 1'b0; wdata = DW'($urandom);
  endtask

  task automatic recv_byte(input logic [DW-1:0] exp, input int stall);
    int t = 0;
    while (!rdata_valid && t < 50) begin tick(); t++; end
    chk("rdata_valid", rdata_valid, 1);
    for (int k = 0; k < stall; k++) begin
      chk("rstall_outs", {mem_cen, mem_wr, mem_rd, rdata_valid}, 4'b1001);
      chk("rdata_stable", rdata, exp);
      tick();
    end
    chk("rdata", rdata, exp);
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  task automatic cmp_events();
    chk("wev_count", act_q.size(), exp_q.size());
    for (int i = ev_idx; i < exp_q.size() && i < act_q.size(); i++) begin
      chk("wev_addr", act_q[i].a, exp_q[i].a);
      chk("wev_data", act_q[i].d, exp_q[i].d);
      chk("wr_hold_clks", act_q[i].n, exp_q[i].n);
    end
    ev_idx = exp_q.size();
    chk("strobe_rules", bad_strobe, 0);
  endtask

  task automatic finish_burst();
    int t = 0;
    while (!done && t < 50) begin tick(); t++; end
    t_done = cyc;
    chk("done", done, 1);
    chk("done_busy_ready", {busy, req_ready}, 2'b10);
    tick();
    chk("done_single_pulse", {done, busy, req_ready}, 3'b001);
    cmp_events();
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len, input int stall);
    wev_t e;
    logic [AW-1:0] aa;
    send_req(1'b1, a, LW'(len));
    for (int i = 0; i <= len; i++) begin
      aa = a + AW'(i);
      e.a = aa; e.d = wbytes[i]; e.n = WRC;
      exp_q.push_back(e);
      ref_mem[aa] = wbytes[i];
      send_byte(wbytes[i], stall);
    end
    finish_burst();
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int len, input int stall);
    logic [AW-1:0] aa;
    send_req(1'b0, a, LW'(len));
    for (int i = 0; i <= len; i++) begin
      aa = a + AW'(i);
      recv_byte(ref_mem[aa], stall);
    end
    finish_burst();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] last_wa;
    int            len, stall, mism;
    wev_t          e;

    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = '0;
    rst = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    tick(); tick();
    chk("reset_ctrl", {mem_cen, mem_wr, mem_rd, rdata_valid, wdata_ready, done, busy}, 7'b1000000);
    chk("reset_add", mem_add, 0);
    chk("reset_din", mem_din, 0);
    chk("reset_rdata", rdata, 0);
    rst = 1'b1;
    tick();

    // single write at the last byte of bank 0
    wbytes = '{8'hA5};
    write_burst(12'h3FF, 0, 0);
    chk("single_mem_3ff", phys_mem[12'h3FF], 8'hA5);

    // bank crossing with no gap
    wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(12'h3FE, 3, 0);
    chk("write_throughput", t_done - t_acc, 4 * (1 + WRC));
    chk("bank0_3fe", phys_mem[12'h3FE], 8'h11);
    chk("bank1_401", phys_mem[12'h401], 8'h44);

    // read-back with consumer backpressure
    read_burst(12'h3FE, 3, 5);

    // top-of-memory wrap
    wbytes = '{8'h5A, 8'hC3};
    write_burst(12'hFFF, 1, 0);
    chk("wrap_fff", phys_mem[12'hFFF], 8'h5A);
    chk("wrap_000", phys_mem[12'h000], 8'hC3);

    // write-data starvation, with stray requests during the stall
    wbytes = '{8'h9E, 8'h47, 8'hB2};
    write_burst(12'h200, 2, 10);
    read_burst(12'h200, 2, 0);

    // reset in the middle of the second write of a four-byte burst
    send_req(1'b1, 12'h100, 8'd3);
    e.a = 12'h100; e.d = 8'hD1; e.n = WRC;
    exp_q.push_back(e);
    ref_mem[12'h100] = 8'hD1;
    send_byte(8'hD1, 0);
    send_byte(8'hE2, 0);
    chk("pre_reset_write", mem_wr, 1);
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", {mem_cen, mem_wr, mem_rd, rdata_valid, wdata_ready, done, busy}, 7'b1000000);
    chk("midreset_add", mem_add, 0);
    chk("midreset_din", mem_din, 0);
    chk("midreset_rdata", rdata, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    cmp_events();
    read_burst(12'h100, 0, 0);
    read_burst(12'h101, 0, 1);

    // random bursts against the byte-array model
    last_wa = 12'h3FE;
    for (int b = 0; b < 25; b++) begin
      len   = $urandom_range(0, 6);
      stall = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = 12'hFFC + AW'($urandom_range(0, 3));
      else                           a = AW'($urandom_range(0, MEM_SIZE - 1));
      if ($urandom_range(0, 1) == 1) begin
        wbytes.delete();
        for (int i = 0; i <= len; i++) wbytes.push_back(DW'($urandom));
        write_burst(a, len, stall);
        last_wa = a;
      end else begin
        if ($urandom_range(0, 1) == 1) a = last_wa;
        read_burst(a, len, stall);
      end
    end

    mism = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (phys_mem[i] !== ref_mem[i]) mism++;
    chk("mem_sweep_mismatches", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
